normalizer_32bit: RTL and testbench

- Iterative 32-bit normalizer: the inverse of the barrel shifter.
- Given a data word, it finds the shift amount that brings the first set bit to the word edge, and returns both the normalized word and that amount.
- The search is a 5-step binary search (16, 8, 4, 2, 1), one step per clock, in the same 5-stage order as the shifter.
- It sits beside the barrel shifter in the datapath, feeding SH_AMT/SH_DIR-compatible values for priority-encode/normalize operations.

---
 rtl/normalizer_32bit.sv | 102 ++++++++++
 tb/tb_normalizer_32bit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/normalizer_32bit.sv
// Iterative 32-bit normalizer: a 5-step binary search (16, 8, 4, 2, 1) for the shift that
// brings the first set bit to the word edge, one step per clock.
module normalizer_32bit #(
  parameter logic [4:0] ZERO_AMT = 5'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        NORM_DIR,
  input  logic [31:0] D_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] D_OUT,
  output logic [4:0]  SH_AMT,
  output logic        ZERO
);

  typedef enum logic [2:0] {IDLE, S16, S8, S4, S2, S1} state_t;

  state_t      state, state_next;
  logic [31:0] w;
  logic [4:0]  a;
  logic        dir;
  logic        zero_cap;

  logic [2:0]  stage_log;
  logic [5:0]  k;
  logic        stage_hit;
  logic [31:0] w_step;
  logic [4:0]  a_step;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every combinationally-assigned signal gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_next = state;
    stage_log  = 3'd0;
    unique case (state)
      IDLE: if (START) state_next = S16;
      S16:  begin stage_log = 3'd4; state_next = S8;   end
      S8:   begin stage_log = 3'd3; state_next = S4;   end
      S4:   begin stage_log = 3'd2; state_next = S2;   end
      S2:   begin stage_log = 3'd1; state_next = S1;   end
      S1:   begin stage_log = 3'd0; state_next = IDLE; end
      default: state_next = IDLE;
    endcase
  end

  // One search step: test the k bits at the working edge and shift them out if all zero.
  always_comb begin
    k         = 6'd1 << stage_log;
    stage_hit = dir ? ((w << (6'd32 - k)) == 32'd0)
                    : ((w >> (6'd32 - k)) == 32'd0);
    w_step    = w;
    a_step    = a;
    if (stage_hit) begin
      w_step = dir ? (w >> k) : (w << k);
      a_step = a | (5'd1 << stage_log);
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (RST) begin
      w        <= '0;
      a        <= '0;
      dir      <= 1'b0;
      zero_cap <= 1'b0;
      DONE     <= 1'b0;
      D_OUT    <= '0;
      SH_AMT   <= '0;
      ZERO     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == IDLE) begin
        if (START) begin
          w        <= D_IN;
          a        <= '0;
          dir      <= NORM_DIR;
          zero_cap <= (D_IN == 32'd0);
        end
      end else begin
        w <= w_step;
        a <= a_step;
        if (state == S1) begin
          D_OUT  <= w_step;
          ZERO   <= zero_cap;
          SH_AMT <= zero_cap ? ZERO_AMT : a_step;
          DONE   <= 1'b1;
        end
      end
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_normalizer_32bit.sv
// Directed and randomized bench for normalizer_32bit; a second instance runs with ZERO_AMT=31.
module tb_normalizer_32bit;

  logic        clk = 1'b0;
  logic        rst, start, norm_dir;
  logic [31:0] d_in;
  logic        busy, done, zero;
  logic [31:0] d_out;
  logic [4:0]  sh_amt;
  logic        busy2, done2, zero2;
  logic [31:0] d_out2;
  logic [4:0]  sh_amt2;

  int checks   = 0;
  int failures = 0;

  normalizer_32bit dut (
    .CLK(clk), .RST(rst), .START(start), .NORM_DIR(norm_dir), .D_IN(d_in),
    .BUSY(busy), .DONE(done), .D_OUT(d_out), .SH_AMT(sh_amt), .ZERO(zero)
  );

  normalizer_32bit #(.ZERO_AMT(5'd31)) dut31 (
    .CLK(clk), .RST(rst), .START(start), .NORM_DIR(norm_dir), .D_IN(d_in),
    .BUSY(busy2), .DONE(done2), .D_OUT(d_out2), .SH_AMT(sh_amt2), .ZERO(zero2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and check latency and all results on both instances.
  task automatic run_norm(input string tag, input logic [31:0] data, input logic dir_in,
                          input logic [31:0] exp_out, input logic [4:0] exp_amt,
                          input logic exp_zero);
    int lat;
    @(negedge clk);
    start = 1'b1; d_in = data; norm_dir = dir_in;
    @(posedge clk); #1;
    start = 1'b0; d_in = ~data; norm_dir = ~dir_in;
    check({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_dout"}, d_out, exp_out);
    check({tag, "_amt"}, sh_amt, exp_amt);
    check({tag, "_zero"}, zero, exp_zero);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_amt31"}, sh_amt2, exp_zero ? 5'd31 : exp_amt);
    check({tag, "_dout31"}, d_out2, exp_out);
  endtask

  initial begin
    int due, next_accept, ndone;
    logic [31:0] hold_exp_out;
    logic [4:0]  hold_exp_amt;
    logic [31:0] v, ref_out;
    logic        rdir;
    int          nz;

    rst = 1'b1; start = 1'b0; norm_dir = 1'b0; d_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", d_out, 32'd0);
    check("rst_amt", sh_amt, 5'd0);
    check("rst_zero", zero, 1'b0);
    @(negedge clk); rst = 1'b0;

    run_norm("l_one",   32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0);
    run_norm("l_12345", 32'h0001_2345, 1'b0, 32'h91A2_8000, 5'd15, 1'b0);
    run_norm("l_ones",  32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 5'd0,  1'b0);
    run_norm("r_a0",    32'h00A0_0000, 1'b1, 32'h0000_0005, 5'd21, 1'b0);
    run_norm("r_msb",   32'h8000_0000, 1'b1, 32'h0000_0001, 5'd31, 1'b0);
    run_norm("r_lsb",   32'h0000_0001, 1'b1, 32'h0000_0001, 5'd0,  1'b0);
    run_norm("l_zero",  32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0,  1'b1);
    run_norm("r_zero",  32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0,  1'b1);

    // START held high with a new word every cycle: only IDLE-edge words are taken,
    // i.e. edges 0, 6, 12 (accept, five stages, then the DONE cycle's closing edge).
    next_accept = 0; due = -1; ndone = 0;
    hold_exp_out = '0; hold_exp_amt = '0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      start = 1'b1; norm_dir = 1'b0;
      d_in = 32'h8000_0000 >> (c + 3);
      if (c == next_accept) begin
        hold_exp_out = 32'h8000_0000;
        hold_exp_amt = 5'(c + 3);
        due = c + 5;
      end
      @(posedge clk); #1;
      if (c == due) begin
        ndone++;
        check("hold_done", done, 1'b1);
        check("hold_dout", d_out, hold_exp_out);
        check("hold_amt", sh_amt, hold_exp_amt);
        next_accept = c + 1;
      end else begin
        check("hold_nodone", done, 1'b0);
      end
    end
    check("hold_ndone", ndone, 3);
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while the search sits in S4: outputs clear and no DONE follows.
    @(negedge clk);
    start = 1'b1; d_in = 32'h0000_0100; norm_dir = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_s4_busy", busy, 1'b0);
    check("rst_s4_done", done, 1'b0);
    check("rst_s4_dout", d_out, 32'd0);
    check("rst_s4_amt", sh_amt, 5'd0);
    check("rst_s4_zero", zero, 1'b0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rst_s4_nodone", ndone, 0);

    // Randomized nonzero words against a bit-by-bit zero count and the round trip.
    for (int n = 0; n < 24; n++) begin
      v = $urandom() >> $urandom_range(31, 0);
      if (v == 32'd0) v = 32'h0000_0400;
      rdir = 1'($urandom_range(1, 0));
      nz = 0;
      if (rdir) begin
        while (v[nz] == 1'b0) nz++;
        ref_out = v >> nz;
      end else begin
        while (v[31 - nz] == 1'b0) nz++;
        ref_out = v << nz;
      end
      run_norm("rand", v, rdir, ref_out, 5'(nz), 1'b0);
      check("rand_roundtrip", rdir ? (d_out << sh_amt) : (d_out >> sh_amt), v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
